// File: rtl/mult_sequencer.sv
// mult_sequencer
// Iterative signed multiplier controller. A 33-bit add/subtract datapath is
// stepped through WIDTH radix-2 Booth iterations. The low WIDTH bits of the
// product are held on data_result. data_exception marks a product that does
// not fit in WIDTH signed bits.
// Only WIDTH = 32 is supported; the 5-bit step counter assumes it.

module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Count value present on the edge that performs the final Booth step.
  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // One Booth add/subtract on the 33-bit accumulator. The carry out of bit 32
  // is discarded. The extra sign bit keeps the sum from wrapping, even for the
  // most negative multiplicand.
  function automatic logic [WIDTH:0] booth_add(
    input logic [1:0]     sel,
    input logic [WIDTH:0] acc,
    input logic [WIDTH:0] mcand
  );
    logic [WIDTH:0] sum;
    case (sel)
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc + ~mcand + {{WIDTH{1'b0}}, 1'b1};
      2'b00:   sum = acc;
      2'b11:   sum = acc;
      default: sum = acc;
    endcase
    return sum;
  endfunction

  // The product fits in WIDTH signed bits only when P[2W:W-1] are all copies
  // of the same bit: every bit above the result matches the result's sign.
  function automatic logic fits_signed(input logic [WIDTH+1:0] upper);
    return (upper == {(WIDTH+2){1'b0}}) || (upper == {(WIDTH+2){1'b1}});
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH:0]   r_mcand;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_mplr;
  logic             r_q_m1;
  logic [4:0]       r_count;

  // Registered outputs.
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_ready;
  logic             r_busy;

  // Combinational next-state and Booth-step results.
  state_t           w_state_nxt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc_shift;
  logic [WIDTH-1:0] w_mplr_shift;
  logic             w_q_shift;
  logic [WIDTH+1:0] w_upper;
  logic             w_overflow;
  logic             w_finish;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // Next-state logic: start in IDLE, count 32 steps in RUN, one cycle in DONE.
  // A start request outside IDLE is not queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ctrl_MULT) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == LAST_STEP) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // High only on the edge where the final Booth step enters DONE.
  always_comb begin
    w_finish = 1'b0;
    if ((r_state == S_RUN) && (w_state_nxt == S_DONE)) begin
      w_finish = 1'b1;
    end else begin
      w_finish = 1'b0;
    end
  end

  // State register. Reset has priority over any start request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Booth datapath
  // ---------------------------------------------------------------------------

  // One Booth step: conditional add/subtract, then a 1-bit arithmetic shift
  // right of {acc, mplr, q_m1}. The shift replicates the accumulator sign.
  always_comb begin
    w_sum        = booth_add({r_mplr[0], r_q_m1}, r_acc, r_mcand);
    w_acc_shift  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_mplr_shift = {w_sum[0], r_mplr[WIDTH-1:1]};
    w_q_shift    = r_mplr[0];
    // Bits P[2W:W-1] of the product this step produces.
    w_upper      = {w_acc_shift, w_mplr_shift[WIDTH-1]};
    w_overflow   = ~fits_signed(w_upper);
  end

  // Datapath registers: load operands on an accepted start, and advance one
  // Booth step per cycle in RUN. They hold in all other cases.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand <= {(WIDTH+1){1'b0}};
      r_acc   <= {(WIDTH+1){1'b0}};
      r_mplr  <= {WIDTH{1'b0}};
      r_q_m1  <= 1'b0;
      r_count <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctrl_MULT) begin
            r_mcand <= {data_operandA[WIDTH-1], data_operandA};
            r_acc   <= {(WIDTH+1){1'b0}};
            r_mplr  <= data_operandB;
            r_q_m1  <= 1'b0;
            r_count <= 5'd0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_shift;
          r_mplr  <= w_mplr_shift;
          r_q_m1  <= w_q_shift;
          r_count <= r_count + 5'd1;
        end
        S_DONE: begin
          r_count <= r_count;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // Output registers. busy and the ready pulse follow the next state, so they
  // change on the same edge as the FSM. The result and exception are captured
  // from the final step and held until the next completed operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result    <= {WIDTH{1'b0}};
      r_exception <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_ready <= (w_state_nxt == S_DONE);
      if (w_finish) begin
        r_result    <= w_mplr_shift;
        r_exception <= w_overflow;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_ready;
  assign busy           = r_busy;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer. Expected products come from a
// 64-bit reference multiply. They are queued at start and popped when the
// ready pulse appears.

module tb_mult_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mult_sequencer #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference: full signed 64-bit product, low word, and overflow flag.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    exp_t        e;
    p     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    e.res = p[31:0];
    e.exc = (p[63:31] != {33{1'b0}}) && (p[63:31] != {33{1'b1}});
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start one multiply, optionally pulse a spurious start at edge E<inject_at>,
  // then wait for ready. Check latency, result, and post-pulse state.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int inject_at);
    exp_t e;
    int   n;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    sb.push_back(model(a, b));
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    @(negedge clock);
    n = 1;
    chk("busy_after_e0", {31'd0, busy}, 32'd1);
    while (!data_resultRDY && n < 40) begin
      if (n == inject_at) begin
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
      end else begin
        ctrl_MULT = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    ctrl_MULT = 1'b0;
    chk("latency", n, 32'd33);
    chk("rdy_high", {31'd0, data_resultRDY}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("result", data_result, e.res);
      chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
      @(negedge clock);
      chk("rdy_low_after", {31'd0, data_resultRDY}, 32'd0);
      chk("busy_low_after", {31'd0, busy}, 32'd0);
      chk("result_held", data_result, e.res);
    end
  endtask

  // Start an operation, reset it at E20, and check that it is abandoned.
  task automatic run_reset_abort();
    int seen;
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (20) @(negedge clock);
    chk("busy_mid_run", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exception", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY || busy) seen++;
    end
    chk("no_activity_after_rst", seen, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    run_mult(32'd3, 32'd5, -1);
    run_mult(32'hFFFF_FFF9, 32'd6, -1);
    run_mult(32'd6, 32'hFFFF_FFF9, -1);
    run_mult(32'h7FFF_FFFF, 32'd2, -1);
    run_mult(32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_mult(32'hFFFF_0000, 32'h0000_8000, -1);
    run_mult(32'h8000_0000, 32'h8000_0000, -1);
    run_mult(32'h0001_0000, 32'h0001_0000, -1);
    run_mult(32'hFFFF_FFFF, 32'h8000_0000, -1);
    // A spurious start at E10 must be ignored.
    run_mult(32'd3, 32'd5, 10);
    run_reset_abort();
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    for (int i = 0; i < 6; i++) begin
      run_mult($urandom, $urandom, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
